// File: rtl/riscv_pkg.sv
// RV32I opcode constants and ALU operation encodings shared by the operand decoder.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ADD_OP  = 4'd0,
    SUB_OP  = 4'd1,
    SLL_OP  = 4'd2,
    XOR_OP  = 4'd3,
    SRL_OP  = 4'd4,
    SRA_OP  = 4'd5,
    OR_OP   = 4'd6,
    AND_OP  = 4'd7,
    PASS_OP = 4'd8
  } alu_op_e;

  // SRL and SRA share all bits but bit0, so instr[30] picks the flavour directly.
  function automatic alu_op_e shift_right_op(input logic arith);
    return alu_op_e'(4'(SRL_OP) | {3'b000, arith});
  endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Purely combinational RV32I decode into ALU opcode and two operands.
module alu_decode_comb
  import riscv_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int ALUOP_WIDTH = 4
) (
  input  logic [31:0]            instr,
  input  logic [DWIDTH-1:0]      pc,
  input  logic [DWIDTH-1:0]      rs1_data,
  input  logic [DWIDTH-1:0]      rs2_data,
  output logic [DWIDTH-1:0]      op1,
  output logic [DWIDTH-1:0]      op2,
  output logic [ALUOP_WIDTH-1:0] aluop,
  output logic                   illegal
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_u;
  alu_op_e            op;
  logic               unused_rs1_idx;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign unused_rs1_idx = ^instr[19:15];

  always_comb begin
    // NOTE: every output gets a default first so no decode path infers a latch.
    op      = PASS_OP;
    op1     = '0;
    op2     = '0;
    illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        op1     = rs1_data;
        op2     = rs2_data;
        illegal = 1'b0;
        case (funct3)
          3'b000:  op = instr[30] ? SUB_OP : ADD_OP;
          3'b001:  op = SLL_OP;
          3'b100:  op = XOR_OP;
          3'b101:  op = shift_right_op(instr[30]);
          3'b110:  op = OR_OP;
          3'b111:  op = AND_OP;
          default: illegal = 1'b1;
        endcase
        if (funct7 != 7'b0000000 && funct7 != 7'b0100000) illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        op1     = rs1_data;
        op2     = DWIDTH'(imm_i);
        illegal = 1'b0;
        case (funct3)
          3'b000: op = ADD_OP;
          3'b001: begin
            op  = SLL_OP;
            op2 = DWIDTH'(instr[24:20]);
          end
          3'b100: op = XOR_OP;
          3'b101: begin
            op  = shift_right_op(instr[30]);
            op2 = DWIDTH'(instr[24:20]);
          end
          3'b110:  op = OR_OP;
          3'b111:  op = AND_OP;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        op      = PASS_OP;
        op2     = DWIDTH'(imm_u);
        illegal = 1'b0;
      end
      OPC_AUIPC: begin
        op      = ADD_OP;
        op1     = pc;
        op2     = DWIDTH'(imm_u);
        illegal = 1'b0;
      end
      OPC_JAL, OPC_JALR: begin
        op      = ADD_OP;
        op1     = pc;
        op2     = DWIDTH'(32'd4);
        illegal = 1'b0;
      end
      OPC_LOAD: begin
        op      = ADD_OP;
        op1     = rs1_data;
        op2     = DWIDTH'(imm_i);
        illegal = 1'b0;
      end
      OPC_STORE: begin
        op      = ADD_OP;
        op1     = rs1_data;
        op2     = DWIDTH'(imm_s);
        illegal = 1'b0;
      end
      OPC_BRANCH: begin
        op      = SUB_OP;
        op1     = rs1_data;
        op2     = rs2_data;
        illegal = 1'b0;
      end
      default: illegal = 1'b1;
    endcase
    // Unsupported encodings present a clean, all-zero PASS so downstream never sees stale operands.
    if (illegal) begin
      op  = PASS_OP;
      op1 = '0;
      op2 = '0;
    end
  end

  assign aluop = ALUOP_WIDTH'(op);

endmodule

// File: rtl/alu_operand_decoder.sv
// Registered ALU operand decoder with valid/ready handshake on both sides.
// Define ALU_DEC_SKID_EN to add a one-entry skid buffer and a registered o_ready.
module alu_operand_decoder
  import riscv_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int ALUOP_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [31:0]            i_instr,
  input  logic [DWIDTH-1:0]      i_pc,
  input  logic [DWIDTH-1:0]      i_rs1_data,
  input  logic [DWIDTH-1:0]      i_rs2_data,
  input  logic                   i_flush,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DWIDTH-1:0]      o_op1,
  output logic [DWIDTH-1:0]      o_op2,
  output logic [ALUOP_WIDTH-1:0] o_aluop,
  output logic                   o_illegal
);

  typedef struct packed {
    logic                   illegal;
    logic [ALUOP_WIDTH-1:0] aluop;
    logic [DWIDTH-1:0]      op1;
    logic [DWIDTH-1:0]      op2;
  } dec_t;

  dec_t dec;
  dec_t load_data;
  dec_t out_q;
  logic out_valid_q;
  logic out_valid_d;
  logic out_load;
  logic accept;

  alu_decode_comb #(
    .DWIDTH      (DWIDTH),
    .ALUOP_WIDTH (ALUOP_WIDTH)
  ) u_decode (
    .instr    (i_instr),
    .pc       (i_pc),
    .rs1_data (i_rs1_data),
    .rs2_data (i_rs2_data),
    .op1      (dec.op1),
    .op2      (dec.op2),
    .aluop    (dec.aluop),
    .illegal  (dec.illegal)
  );

`ifdef ALU_DEC_SKID_EN
  dec_t skid_q;
  logic skid_valid_q;
  logic skid_valid_d;
  logic skid_load;
  logic ready_q;

  assign o_ready   = ready_q;
  assign accept    = i_valid && ready_q && !i_flush;
  assign load_data = skid_valid_q ? skid_q : dec;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_load     = 1'b0;
    skid_valid_d = skid_valid_q;
    skid_load    = 1'b0;
    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || i_ready) begin
      // Skid entry is older than anything arriving now, so it drains first.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_load     = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        out_load    = accept;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_load    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end

  // NOTE: the skid payload needs no reset; skid_valid_q alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (skid_load) skid_q <= dec;
  end
`else
  logic run_q;

  assign o_ready   = run_q && (!out_valid_q || i_ready);
  assign accept    = i_valid && o_ready && !i_flush;
  assign load_data = dec;

  always_comb begin
    out_valid_d = out_valid_q;
    out_load    = 1'b0;
    if (i_flush) begin
      out_valid_d = 1'b0;
    end else if (!out_valid_q || i_ready) begin
      out_valid_d = accept;
      out_load    = accept;
    end
  end

  // Holds o_ready low through reset and releases it on the first edge afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state updates use <= so every register samples pre-edge values.
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      out_q.illegal <= 1'b0;
      out_q.aluop   <= ALUOP_WIDTH'(ADD_OP);
      out_q.op1     <= '0;
      out_q.op2     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (out_load) out_q <= load_data;
    end
  end

  assign o_valid   = out_valid_q;
  assign o_op1     = out_q.op1;
  assign o_op2     = out_q.op2;
  assign o_aluop   = out_q.aluop;
  assign o_illegal = out_q.illegal;

endmodule
